// File: rtl/video_timing_pkg.sv
// Shared raster timing constants, phase encoding and counter widths
// for the character-clock video sync generator.
package video_timing_pkg;

    localparam int DEF_H_VISIBLE = 132;
    localparam int DEF_H_FRONT   = 5;
    localparam int DEF_H_SYNC    = 16;
    localparam int DEF_H_BACK    = 11;

    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FRONT   = 1;
    localparam int DEF_V_SYNC    = 4;
    localparam int DEF_V_BACK    = 23;

    localparam int CHAR_W = 8;
    localparam int LINE_W = 12;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

endpackage

// File: rtl/video_sync_gen_sync_axis.sv
// One raster axis: position counter plus phase FSM, both stepped by advance.
// The phase comes from a phase-local down-counter, never from position compares.
module sync_axis
    import video_timing_pkg::*;
#(
    parameter int LEN_ACTIVE = 1,
    parameter int LEN_FRONT  = 1,
    parameter int LEN_SYNC   = 1,
    parameter int LEN_BACK   = 1,
    parameter int W          = 8
) (
    input  logic         char_clock,
    input  logic         reset,
    input  logic         advance,
    output logic         wrap,
    output logic [W-1:0] pos,
    output phase_t       phase
);

    localparam int TOTAL = LEN_ACTIVE + LEN_FRONT + LEN_SYNC + LEN_BACK;

    if (TOTAL > (2 ** W)) begin : g_total_chk
        $error("sync_axis: total length does not fit counter width");
    end
    if (LEN_ACTIVE < 1 || LEN_FRONT < 1 || LEN_SYNC < 1 || LEN_BACK < 1) begin : g_len_chk
        $error("sync_axis: every phase needs at least one step");
    end

    logic [W-1:0] r_pos;
    logic [W-1:0] r_left;
    phase_t       r_phase;

    logic [W-1:0] w_pos_nxt;
    logic [W-1:0] w_left_nxt;
    phase_t       w_phase_nxt;
    logic         w_last;

    function automatic logic [W-1:0] len_m1(input phase_t p);
        logic [W-1:0] v;
        v = W'(LEN_ACTIVE - 1);
        unique case (p)
            ACTIVE: v = W'(LEN_ACTIVE - 1);
            FRONT:  v = W'(LEN_FRONT - 1);
            SYNC:   v = W'(LEN_SYNC - 1);
            BACK:   v = W'(LEN_BACK - 1);
        endcase
        return v;
    endfunction

    assign w_last = (r_left == '0);
    assign wrap   = advance && w_last && (r_phase == BACK);
    assign pos    = r_pos;
    assign phase  = r_phase;

    always_comb begin
        w_pos_nxt   = r_pos;
        w_left_nxt  = r_left;
        w_phase_nxt = r_phase;
        if (advance) begin
            w_pos_nxt = wrap ? '0 : r_pos + 1'b1;
            if (w_last) begin
                unique case (r_phase)
                    ACTIVE: w_phase_nxt = FRONT;
                    FRONT:  w_phase_nxt = SYNC;
                    SYNC:   w_phase_nxt = BACK;
                    BACK:   w_phase_nxt = ACTIVE;
                endcase
                w_left_nxt = len_m1(w_phase_nxt);
            end else begin
                w_left_nxt = r_left - 1'b1;
            end
        end
    end

    always_ff @(posedge char_clock) begin
        if (reset) begin
            r_pos   <= '0;
            r_left  <= W'(LEN_ACTIVE - 1);
            r_phase <= ACTIVE;
        end else begin
            r_pos   <= w_pos_nxt;
            r_left  <= w_left_nxt;
            r_phase <= w_phase_nxt;
        end
    end

endmodule

// File: rtl/video_sync_gen.sv
// Raster timing generator: counters for the renderer, sync/visible
// delayed one char_clock to line up with registered consumer video.
module video_sync_gen
    import video_timing_pkg::*;
#(
    parameter int   H_VISIBLE = DEF_H_VISIBLE,
    parameter int   H_FRONT   = DEF_H_FRONT,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BACK    = DEF_H_BACK,
    parameter int   V_VISIBLE = DEF_V_VISIBLE,
    parameter int   V_FRONT   = DEF_V_FRONT,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BACK    = DEF_V_BACK,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic              char_clock,
    input  logic              reset,
    output logic [CHAR_W-1:0] char_count,
    output logic [LINE_W-1:0] line_count,
    output logic              pre_visible,
    output logic              visible,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 256) begin : g_h_chk
        $error("video_sync_gen: H_TOTAL exceeds 256");
    end
    if (V_TOTAL > 4096) begin : g_v_chk
        $error("video_sync_gen: V_TOTAL exceeds 4096");
    end

    logic   r_started;
    logic   r_visible;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_frame_tick;

    logic   w_h_wrap;
    logic   w_v_wrap;
    phase_t w_h_phase;
    phase_t w_v_phase;
    logic   w_hsync_raw;
    logic   w_vsync_raw;

    // Counters hold at 0 for the first cycle after reset so (0,0) is seen.
    sync_axis #(
        .LEN_ACTIVE (H_VISIBLE),
        .LEN_FRONT  (H_FRONT),
        .LEN_SYNC   (H_SYNC),
        .LEN_BACK   (H_BACK),
        .W          (CHAR_W)
    ) u_h_axis (
        .char_clock (char_clock),
        .reset      (reset),
        .advance    (r_started),
        .wrap       (w_h_wrap),
        .pos        (char_count),
        .phase      (w_h_phase)
    );

    sync_axis #(
        .LEN_ACTIVE (V_VISIBLE),
        .LEN_FRONT  (V_FRONT),
        .LEN_SYNC   (V_SYNC),
        .LEN_BACK   (V_BACK),
        .W          (LINE_W)
    ) u_v_axis (
        .char_clock (char_clock),
        .reset      (reset),
        .advance    (w_h_wrap),
        .wrap       (w_v_wrap),
        .pos        (line_count),
        .phase      (w_v_phase)
    );

    assign w_hsync_raw = (w_h_phase == SYNC);
    assign w_vsync_raw = (w_v_phase == SYNC);

    assign pre_visible = r_started
                       && (w_h_phase == ACTIVE)
                       && (w_v_phase == ACTIVE);

    always_ff @(posedge char_clock) begin
        if (reset) begin
            r_started    <= 1'b0;
            r_visible    <= 1'b0;
            r_hsync      <= ~HSYNC_POL;
            r_vsync      <= ~VSYNC_POL;
            r_frame_tick <= 1'b0;
        end else begin
            r_started    <= 1'b1;
            r_visible    <= pre_visible;
            r_hsync      <= w_hsync_raw ~^ HSYNC_POL;
            r_vsync      <= w_vsync_raw ~^ VSYNC_POL;
            r_frame_tick <= !r_started || (w_h_wrap && w_v_wrap);
        end
    end

    assign visible    = r_visible;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_video_sync_gen.sv
// Directed bench: default-timing instance plus a tiny-raster instance
// used for frame wrap, vertical sync width and mid-frame reset.
module tb_video_sync_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_s = 1'b1;

    logic [7:0]  d_c;
    logic [11:0] d_l;
    logic        d_pv, d_v, d_hs, d_vs, d_t;
    logic [7:0]  s_c;
    logic [11:0] s_l;
    logic        s_pv, s_v, s_hs, s_vs, s_t;

    int n;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_sync_gen dut (
        .char_clock  (clk),
        .reset       (rst),
        .char_count  (d_c),
        .line_count  (d_l),
        .pre_visible (d_pv),
        .visible     (d_v),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .frame_tick  (d_t)
    );

    video_sync_gen #(
        .H_VISIBLE (4),
        .H_FRONT   (1),
        .H_SYNC    (2),
        .H_BACK    (1),
        .V_VISIBLE (3),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1),
        .HSYNC_POL (1'b1),
        .VSYNC_POL (1'b0)
    ) dut_s (
        .char_clock  (clk),
        .reset       (rst_s),
        .char_count  (s_c),
        .line_count  (s_l),
        .pre_visible (s_pv),
        .visible     (s_v),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .frame_tick  (s_t)
    );

    typedef struct {
        int n;
        bit s;
        int c;
        int l;
        int pv;
        int v;
        int hs;
        int vs;
        int t;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int n_, bit s_, int c_, int l_, int pv_,
                                int v_, int hs_, int vs_, int t_);
        vec_t r;
        r.n = n_; r.s = s_; r.c = c_; r.l = l_; r.pv = pv_;
        r.v = v_; r.hs = hs_; r.vs = vs_; r.t = t_;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s n=%0d got %0d want %0d", nm, n, act, exp);
        end
    endtask

    task automatic chk_vec(vec_t r);
        if (r.s) begin
            chk("s_char", int'(s_c), r.c);
            chk("s_line", int'(s_l), r.l);
            chk("s_pre_visible", int'(s_pv), r.pv);
            chk("s_visible", int'(s_v), r.v);
            chk("s_hsync", int'(s_hs), r.hs);
            chk("s_vsync", int'(s_vs), r.vs);
            chk("s_frame_tick", int'(s_t), r.t);
        end else begin
            chk("d_char", int'(d_c), r.c);
            chk("d_line", int'(d_l), r.l);
            chk("d_pre_visible", int'(d_pv), r.pv);
            chk("d_visible", int'(d_v), r.v);
            chk("d_hsync", int'(d_hs), r.hs);
            chk("d_vsync", int'(d_vs), r.vs);
            chk("d_frame_tick", int'(d_t), r.t);
        end
    endtask

    initial begin
        int ticks;
        int lows;
        int runs;
        int first;
        int bad;
        logic prev_vs;

        //               n    s  c    l  pv v  hs vs t
        tbl.push_back(mk(0,   0, 0,   0, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0,   1, 0,   0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1,   0, 1,   0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1,   1, 1,   0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(4,   1, 4,   0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(5,   1, 5,   0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(6,   1, 6,   0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(7,   1, 7,   0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(8,   1, 0,   1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(24,  1, 0,   3, 0, 0, 0, 1, 0));
        tbl.push_back(mk(28,  1, 4,   3, 0, 0, 0, 1, 0));
        tbl.push_back(mk(32,  1, 0,   4, 0, 0, 0, 1, 0));
        tbl.push_back(mk(33,  1, 1,   4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(48,  1, 0,   6, 0, 0, 0, 0, 0));
        tbl.push_back(mk(49,  1, 1,   6, 0, 0, 0, 1, 0));
        tbl.push_back(mk(55,  1, 7,   6, 0, 0, 1, 1, 0));
        tbl.push_back(mk(56,  1, 0,   0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(57,  1, 1,   0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(131, 0, 131, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(132, 0, 132, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(133, 0, 133, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(137, 0, 137, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(138, 0, 138, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(153, 0, 153, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(154, 0, 154, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(163, 0, 163, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(164, 0, 0,   1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(165, 0, 1,   1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(302, 0, 138, 1, 0, 0, 0, 1, 0));

        n = 0;
        repeat (5) @(negedge clk);
        chk("rst_d_char", int'(d_c), 0);
        chk("rst_d_line", int'(d_l), 0);
        chk("rst_d_pre_visible", int'(d_pv), 0);
        chk("rst_d_visible", int'(d_v), 0);
        chk("rst_d_frame_tick", int'(d_t), 0);
        chk("rst_d_hsync", int'(d_hs), 1);
        chk("rst_d_vsync", int'(d_vs), 1);
        chk("rst_s_hsync", int'(s_hs), 0);
        chk("rst_s_vsync", int'(s_vs), 1);

        rst   = 1'b0;
        rst_s = 1'b0;
        n = -1;
        step();

        foreach (tbl[i]) begin
            while (n < tbl[i].n) step();
            chk_vec(tbl[i]);
        end

        // Full small frame starting at a frame boundary.
        while (n < 336) step();
        ticks = 0;
        lows = 0;
        runs = 0;
        first = -1;
        prev_vs = 1'b1;
        for (int k = 0; k < 56; k++) begin
            if (k > 0) step();
            if (s_t) ticks++;
            if (!s_vs) begin
                lows++;
                if (prev_vs) begin
                    runs++;
                    if (first < 0) first = n;
                end
            end
            prev_vs = s_vs;
        end
        chk("frame_tick_count", ticks, 1);
        chk("vsync_low_cycles", lows, 16);
        chk("vsync_low_runs", runs, 1);
        chk("vsync_low_start", first, 369);
        chk("pre_wrap_char", int'(s_c), 7);
        chk("pre_wrap_line", int'(s_l), 6);
        step();
        chk("wrap_char", int'(s_c), 0);
        chk("wrap_line", int'(s_l), 0);
        chk("wrap_tick", int'(s_t), 1);
        chk("d_line2_char", int'(d_c), 64);
        chk("d_line2_line", int'(d_l), 2);
        chk("d_line2_pre_visible", int'(d_pv), 1);

        // Reset pulse in the middle of vertical sync and hsync.
        while (n < 437) step();
        chk("mid_char", int'(s_c), 5);
        chk("mid_line", int'(s_l), 5);
        chk("mid_vsync_active", int'(s_vs), 0);
        rst_s = 1'b1;
        step();
        chk("mr_char", int'(s_c), 0);
        chk("mr_line", int'(s_l), 0);
        chk("mr_hsync", int'(s_hs), 0);
        chk("mr_vsync", int'(s_vs), 1);
        chk("mr_pre_visible", int'(s_pv), 0);
        chk("mr_visible", int'(s_v), 0);
        chk("mr_tick", int'(s_t), 0);
        rst_s = 1'b0;
        step();
        chk("rel_char", int'(s_c), 0);
        chk("rel_line", int'(s_l), 0);
        chk("rel_pre_visible", int'(s_pv), 1);
        chk("rel_visible", int'(s_v), 0);
        chk("rel_tick", int'(s_t), 1);
        chk("rel_vsync", int'(s_vs), 1);
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (!s_vs) bad++;
            if (k == 1) chk("rel_visible_next", int'(s_v), 1);
            if (k == 6) chk("rel_hsync_fresh", int'(s_hs), 1);
        end
        chk("rel_no_stray_vsync", bad, 0);
        step();
        chk("rel_vsync_start", int'(s_vs), 0);
        chk("rel_vsync_line", int'(s_l), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_sync_gen.md
# video_sync_gen

Raster timing generator on `char_clock`. Drives `char_count`, `line_count` and `pre_visible` into the game/renderer blocks, and produces `hsync`/`vsync` for the DAC/connector. Consumers register their video one `char_clock` after sampling the counters. This block therefore delays `hsync`, `vsync` and `visible` by one cycle so they stay aligned with consumer video.

## Interface
- `H_VISIBLE`, 132: visible characters per line
- `H_FRONT`, 5: horizontal front porch, characters
- `H_SYNC`, 16: hsync width, characters
- `H_BACK`, 11: horizontal back porch, characters
- `V_VISIBLE`, 600: visible lines
- `V_FRONT`, 1: vertical front porch, lines
- `V_SYNC`, 4: vsync width, lines
- `V_BACK`, 23: vertical back porch, lines
- `HSYNC_POL`, 0: active level of `hsync`
- `VSYNC_POL`, 0: active level of `vsync`
- `char_clock` input 1: character clock; sole clock
- `reset` input 1: synchronous, active-high
- `char_count` output 8: horizontal position, 0..H_TOTAL-1
- `line_count` output 12: vertical position, 0..V_TOTAL-1
- `pre_visible` output 1: current counter position is visible, aligned with counters
- `visible` output 1: `pre_visible` delayed 1 cycle, aligned with consumer video
- `hsync` output 1: horizontal sync, delayed 1 cycle
- `vsync` output 1: vertical sync, delayed 1 cycle; glitch-free register output; consumers clock on its edge
- `frame_tick` output 1: one-cycle pulse when counters are at (0,0)

## Operation
- Totals: H_TOTAL = sum of the four H parameters (164); V_TOTAL = sum of the four V parameters (628). Elaboration error if H_TOTAL > 256 or V_TOTAL > 4096.
- Horizontal phase FSM: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - Each phase lasts its parameter count in characters.
  - `char_count` increments every cycle and wraps from H_TOTAL-1 to 0, entering ACTIVE.
- Vertical phase FSM uses the same four states. It advances only on the horizontal wrap cycle, when `line_count` increments.
  - `line_count` wraps from V_TOTAL-1 to 0.
- `pre_visible` = horizontal ACTIVE and vertical ACTIVE, i.e. `char_count` < H_VISIBLE and `line_count` < V_VISIBLE.
- The raw sync is active while the corresponding FSM is in SYNC:
  - `char_count` in [137,152] with defaults;
  - `line_count` in [601,604] with defaults.
  - Raw vsync changes only on line boundaries.
- `hsync`/`vsync` output = raw sync XNOR polarity parameter, registered once.
- Reset, while high: counters 0, both FSMs ACTIVE, `pre_visible` 0, `visible` 0, `frame_tick` 0, `hsync` = !HSYNC_POL, `vsync` = !VSYNC_POL.
- Reset asserted mid-frame: takes effect at the next edge; no partial sync pulse is extended.
- Counter and phase are never allowed to disagree. Phase is derived from registered phase counters, not from magnitude compares on a possibly-glitching path.

## Timing
- Cycle 0 = first edge with `reset` low: `char_count` = 0, `line_count` = 0, `pre_visible` = 1, `frame_tick` = 1.
- Cycle 1: `visible` = 1.
- Latency:
  - counters → `pre_visible`: 0 cycles;
  - `pre_visible` → `visible`: 1 cycle;
  - raw sync → pin: 1 cycle.
- Line period: H_TOTAL cycles. Frame period: H_TOTAL × V_TOTAL cycles (102992 with defaults).
- `frame_tick` is high exactly one cycle per frame.
- `vsync` rises and falls only in the cycle after a `char_count` = 0 cycle.
- All outputs are registered; no combinational path from `reset` to any output.

## Structure
- Shared package `video_timing_pkg`:
  - default timing constants (800×600-class set above);
  - phase enum {ACTIVE, FRONT, SYNC, BACK};
  - widths CHAR_W = 8, LINE_W = 12.
- One sub-module, `sync_axis`, instanced twice (horizontal and vertical). Each instance holds:
  - the position counter and phase FSM with phase-local down-counter;
  - ports: `advance` enable, `wrap` out, `pos` out, `phase` out;
  - parameters: the four lengths and counter width.
- Vertical `advance` = horizontal `wrap`. Top level holds the output registers and polarity logic.

## Test plan
- Reset release: `reset` high 5 cycles then low → during reset `hsync` = `vsync` = 1 and all other outputs 0; first cycle after release `char_count` = 0, `line_count` = 0, `pre_visible` = 1, `frame_tick` = 1; next cycle `visible` = 1.
- Horizontal timing over one line: `pre_visible` high for `char_count` 0..131 and low 132..163; `hsync` low in the cycles following `char_count` 137..152; `char_count` goes 163 → 0 and `line_count` +1 on that cycle.
- Frame wrap: run 102992 cycles → `line_count` 627 → 0 and `char_count` 163 → 0 together; `frame_tick` high once; `vsync` low for exactly 4×164 = 656 consecutive cycles, starting the cycle after `line_count` becomes 601.
- Vertical blanking: `pre_visible` = 0 for all of lines 600..627 regardless of `char_count`.
- Reset mid-frame: assert `reset` for 1 cycle at `line_count` = 602, `char_count` = 140 → next cycle counters 0, `vsync` = `hsync` = 1; fresh frame from cycle after release with no truncated-pulse artefacts.
- Parameter override: H_VISIBLE = 4, H_FRONT = 1, H_SYNC = 2, H_BACK = 1, HSYNC_POL = 1 → line period 8; `hsync` high in the cycles after `char_count` 5..6.
